// File: rtl/mult_rr_arbiter.sv
// Round-robin front end sharing one pipelined 16x16 multiplier
// between two requesters, with a tag pipeline to route products back.
module mult_rr_arbiter #(
  parameter int MULT_LAT = 2,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [15:0]      a_x,
  input  logic [15:0]      a_y,
  output logic [31:0]      a_p,
  output logic             a_p_valid,
  input  logic             b_valid,
  output logic             b_ready,
  input  logic [15:0]      b_x,
  input  logic [15:0]      b_y,
  output logic [31:0]      b_p,
  output logic             b_p_valid,
  output logic [15:0]      mul_x,
  output logic [15:0]      mul_y,
  input  logic [31:0]      mul_p,
  output logic [3:0]       inflight,
  output logic [CNT_W-1:0] a_done_cnt,
  output logic [CNT_W-1:0] b_done_cnt
);

  localparam logic ID_A = 1'b0;
  localparam logic ID_B = 1'b1;

  typedef struct packed {
    logic vld;
    logic id;
  } tag_t;

  // One stage beyond MULT_LAT so the last tag lines up with mul_p.
  tag_t             r_tag [MULT_LAT+1];
  logic             r_last_grant;
  logic [15:0]      r_mul_x;
  logic [15:0]      r_mul_y;
  logic [31:0]      r_a_p;
  logic [31:0]      r_b_p;
  logic             r_a_p_valid;
  logic             r_b_p_valid;
  logic [3:0]       r_inflight;
  logic [CNT_W-1:0] r_a_cnt;
  logic [CNT_W-1:0] r_b_cnt;

  logic             w_a_ready;
  logic             w_b_ready;
  logic             w_issue;
  logic             w_issue_id;
  logic             w_dlv;
  logic             w_dlv_a;
  logic             w_dlv_b;
  logic [3:0]       w_inflight_nxt;

  always_comb begin
    w_a_ready = 1'b0;
    w_b_ready = 1'b0;
    if (!rst) begin
      case ({a_valid, b_valid})
        2'b10: w_a_ready = 1'b1;
        2'b01: w_b_ready = 1'b1;
        2'b11: begin
          if (r_last_grant == ID_B) begin
            w_a_ready = 1'b1;
          end else begin
            w_b_ready = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign w_issue    = w_a_ready | w_b_ready;
  assign w_issue_id = w_b_ready ? ID_B : ID_A;

  assign w_dlv   = r_tag[MULT_LAT].vld;
  assign w_dlv_a = w_dlv && (r_tag[MULT_LAT].id == ID_A);
  assign w_dlv_b = w_dlv && (r_tag[MULT_LAT].id == ID_B);

  always_comb begin
    w_inflight_nxt = r_inflight;
    case ({w_issue, w_dlv})
      2'b10: w_inflight_nxt = r_inflight + 4'd1;
      2'b01: begin
        if (r_inflight != 4'd0) begin
          w_inflight_nxt = r_inflight - 4'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k <= MULT_LAT; k++) begin
        r_tag[k] <= '0;
      end
      r_last_grant <= ID_B;
      r_mul_x      <= '0;
      r_mul_y      <= '0;
      r_a_p        <= '0;
      r_b_p        <= '0;
      r_a_p_valid  <= 1'b0;
      r_b_p_valid  <= 1'b0;
      r_inflight   <= '0;
      r_a_cnt      <= '0;
      r_b_cnt      <= '0;
    end else begin
      r_tag[0].vld <= w_issue;
      r_tag[0].id  <= w_issue_id;
      for (int k = 1; k <= MULT_LAT; k++) begin
        r_tag[k] <= r_tag[k-1];
      end

      if (w_issue) begin
        r_last_grant <= w_issue_id;
        r_mul_x      <= w_b_ready ? b_x : a_x;
        r_mul_y      <= w_b_ready ? b_y : a_y;
      end

      r_a_p_valid <= w_dlv_a;
      r_b_p_valid <= w_dlv_b;
      if (w_dlv_a) begin
        r_a_p   <= mul_p;
        r_a_cnt <= r_a_cnt + CNT_W'(1);
      end
      if (w_dlv_b) begin
        r_b_p   <= mul_p;
        r_b_cnt <= r_b_cnt + CNT_W'(1);
      end

      r_inflight <= w_inflight_nxt;
    end
  end

  assign a_ready    = w_a_ready;
  assign b_ready    = w_b_ready;
  assign a_p        = r_a_p;
  assign b_p        = r_b_p;
  assign a_p_valid  = r_a_p_valid;
  assign b_p_valid  = r_b_p_valid;
  assign mul_x      = r_mul_x;
  assign mul_y      = r_mul_y;
  assign inflight   = r_inflight;
  assign a_done_cnt = r_a_cnt;
  assign b_done_cnt = r_b_cnt;

endmodule

// File: tb/tb_mult_rr_arbiter.sv
// Directed bench for mult_rr_arbiter with a 2-stage multiplier model.
// A second instance with 4-bit counters covers counter wrap.
module tb_mult_rr_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        a_valid = 1'b0;
  logic        b_valid = 1'b0;
  logic [15:0] a_x = '0;
  logic [15:0] a_y = '0;
  logic [15:0] b_x = '0;
  logic [15:0] b_y = '0;
  logic        a_ready, b_ready;
  logic [31:0] a_p, b_p;
  logic        a_p_valid, b_p_valid;
  logic [15:0] mul_x, mul_y;
  logic [31:0] mul_p;
  logic [3:0]  inflight;
  logic [15:0] a_done_cnt, b_done_cnt;

  logic        w4_a_ready, w4_b_ready;
  logic [31:0] w4_a_p, w4_b_p;
  logic        w4_a_p_valid, w4_b_p_valid;
  logic [15:0] w4_mul_x, w4_mul_y;
  logic [3:0]  w4_inflight;
  logic [3:0]  w4_a_cnt, w4_b_cnt;

  logic [31:0] m_s1 = '0;
  logic [31:0] m_p  = '0;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    m_s1 <= 32'(mul_x) * 32'(mul_y);
    m_p  <= m_s1;
  end
  assign mul_p = m_p;

  mult_rr_arbiter #(.MULT_LAT(2), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready),
    .a_x(a_x), .a_y(a_y),
    .a_p(a_p), .a_p_valid(a_p_valid),
    .b_valid(b_valid), .b_ready(b_ready),
    .b_x(b_x), .b_y(b_y),
    .b_p(b_p), .b_p_valid(b_p_valid),
    .mul_x(mul_x), .mul_y(mul_y), .mul_p(mul_p),
    .inflight(inflight),
    .a_done_cnt(a_done_cnt), .b_done_cnt(b_done_cnt)
  );

  mult_rr_arbiter #(.MULT_LAT(2), .CNT_W(4)) u_dut4 (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(w4_a_ready),
    .a_x(a_x), .a_y(a_y),
    .a_p(w4_a_p), .a_p_valid(w4_a_p_valid),
    .b_valid(b_valid), .b_ready(w4_b_ready),
    .b_x(b_x), .b_y(b_y),
    .b_p(w4_b_p), .b_p_valid(w4_b_p_valid),
    .mul_x(w4_mul_x), .mul_y(w4_mul_y), .mul_p(mul_p),
    .inflight(w4_inflight),
    .a_done_cnt(w4_a_cnt), .b_done_cnt(w4_b_cnt)
  );

  typedef struct packed {
    logic        rb;
    logic        av;
    logic        bv;
    logic [15:0] ax;
    logic [15:0] ay;
    logic [15:0] bx;
    logic [15:0] by;
    logic        ar;
    logic        br;
    logic        apv;
    logic        bpv;
    logic [31:0] ap;
    logic [31:0] bp;
    logic [15:0] mx;
    logic [15:0] my;
    logic [3:0]  inf;
    logic [15:0] ac;
    logic [15:0] bc;
  } vec_t;

  localparam int NV = 24;
  vec_t tbl [NV];

  function automatic vec_t v(
    input bit rb, input bit av, input bit bv,
    input int ax, input int ay, input int bx, input int by,
    input bit ar, input bit br, input bit apv, input bit bpv,
    input int ap, input int bp, input int mx, input int my,
    input int inf, input int ac, input int bc
  );
    vec_t r;
    r.rb  = rb;
    r.av  = av;
    r.bv  = bv;
    r.ax  = 16'(ax);
    r.ay  = 16'(ay);
    r.bx  = 16'(bx);
    r.by  = 16'(by);
    r.ar  = ar;
    r.br  = br;
    r.apv = apv;
    r.bpv = bpv;
    r.ap  = 32'(ap);
    r.bp  = 32'(bp);
    r.mx  = 16'(mx);
    r.my  = 16'(my);
    r.inf = 4'(inf);
    r.ac  = 16'(ac);
    r.bc  = 16'(bc);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    a_valid = 1'b0;
    b_valid = 1'b0;
    a_x = '0;
    a_y = '0;
    b_x = '0;
    b_y = '0;
  endtask

  task automatic do_reset();
    idle_in();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  logic sa_av [7];
  logic sa_bv [7];
  logic sa_ar [7];
  logic sa_br [7];

  initial begin
    // cycle-by-cycle vectors; rb=1 resets before the row
    tbl[0]  = v(1,1,0,3,5,0,0, 1,0,0,0, 0,0, 0,0, 0, 0,0);
    tbl[1]  = v(0,0,0,0,0,0,0, 0,0,0,0, 0,0, 3,5, 1, 0,0);
    tbl[2]  = v(0,0,0,0,0,0,0, 0,0,0,0, 0,0, 3,5, 1, 0,0);
    tbl[3]  = v(0,0,0,0,0,0,0, 0,0,0,0, 0,0, 3,5, 1, 0,0);
    tbl[4]  = v(0,0,0,0,0,0,0, 0,0,1,0, 15,0, 3,5, 0, 1,0);
    tbl[5]  = v(0,0,0,0,0,0,0, 0,0,0,0, 15,0, 3,5, 0, 1,0);
    tbl[6]  = v(1,1,1,1,2,11,12, 1,0,0,0, 0,0, 0,0, 0, 0,0);
    tbl[7]  = v(0,1,1,3,4,11,12, 0,1,0,0, 0,0, 1,2, 1, 0,0);
    tbl[8]  = v(0,1,1,3,4,13,14, 1,0,0,0, 0,0, 11,12, 2, 0,0);
    tbl[9]  = v(0,1,1,5,6,13,14, 0,1,0,0, 0,0, 3,4, 3, 0,0);
    tbl[10] = v(0,1,1,5,6,15,16, 1,0,1,0, 2,0, 13,14, 3, 1,0);
    tbl[11] = v(0,1,1,7,8,15,16, 0,1,0,1, 2,132, 5,6, 3, 1,1);
    tbl[12] = v(0,1,1,7,8,17,18, 1,0,1,0, 12,132, 15,16, 3, 2,1);
    tbl[13] = v(0,1,1,9,10,17,18, 0,1,0,1, 12,182, 7,8, 3, 2,2);
    tbl[14] = v(0,0,0,0,0,0,0, 0,0,1,0, 30,182, 17,18, 3, 3,2);
    tbl[15] = v(0,0,0,0,0,0,0, 0,0,0,1, 30,240, 17,18, 2, 3,3);
    tbl[16] = v(0,0,0,0,0,0,0, 0,0,1,0, 56,240, 17,18, 1, 4,3);
    tbl[17] = v(0,0,0,0,0,0,0, 0,0,0,1, 56,306, 17,18, 0, 4,4);
    tbl[18] = v(0,0,1,0,0,'hFFFF,'hFFFF, 0,1,0,0,
                56,306, 17,18, 0, 4,4);
    tbl[19] = v(0,0,0,0,0,0,0, 0,0,0,0,
                56,306, 'hFFFF,'hFFFF, 1, 4,4);
    tbl[20] = v(0,0,0,0,0,0,0, 0,0,0,0,
                56,306, 'hFFFF,'hFFFF, 1, 4,4);
    tbl[21] = v(0,0,0,0,0,0,0, 0,0,0,0,
                56,306, 'hFFFF,'hFFFF, 1, 4,4);
    tbl[22] = v(0,0,0,0,0,0,0, 0,0,0,1,
                56,'hFFFE0001, 'hFFFF,'hFFFF, 0, 4,5);
    tbl[23] = v(0,0,0,0,0,0,0, 0,0,0,0,
                56,'hFFFE0001, 'hFFFF,'hFFFF, 0, 4,5);

    sa_av = '{1, 1, 1, 0, 1, 0, 1};
    sa_bv = '{0, 1, 1, 1, 0, 0, 1};
    sa_ar = '{1, 0, 1, 0, 1, 0, 0};
    sa_br = '{0, 1, 0, 1, 0, 0, 1};

    // reset state, readies held low while rst is high
    tick();
    rst = 1'b1;
    a_valid = 1'b1;
    b_valid = 1'b1;
    #1;
    chk("rst a_ready", 32'(a_ready), 0);
    chk("rst b_ready", 32'(b_ready), 0);
    tick();
    tick();
    chk("rst a_p", a_p, 0);
    chk("rst b_p", b_p, 0);
    chk("rst mul_x", 32'(mul_x), 0);
    chk("rst inflight", 32'(inflight), 0);
    chk("rst a_cnt", 32'(a_done_cnt), 0);
    rst = 1'b0;
    idle_in();

    for (int i = 0; i < NV; i++) begin
      if (tbl[i].rb) do_reset();
      a_valid = tbl[i].av;
      b_valid = tbl[i].bv;
      a_x = tbl[i].ax;
      a_y = tbl[i].ay;
      b_x = tbl[i].bx;
      b_y = tbl[i].by;
      #1;
      chk($sformatf("row%0d a_ready", i), 32'(a_ready), 32'(tbl[i].ar));
      chk($sformatf("row%0d b_ready", i), 32'(b_ready), 32'(tbl[i].br));
      chk($sformatf("row%0d a_p_valid", i), 32'(a_p_valid),
          32'(tbl[i].apv));
      chk($sformatf("row%0d b_p_valid", i), 32'(b_p_valid),
          32'(tbl[i].bpv));
      chk($sformatf("row%0d a_p", i), a_p, tbl[i].ap);
      chk($sformatf("row%0d b_p", i), b_p, tbl[i].bp);
      chk($sformatf("row%0d mul_x", i), 32'(mul_x), 32'(tbl[i].mx));
      chk($sformatf("row%0d mul_y", i), 32'(mul_y), 32'(tbl[i].my));
      chk($sformatf("row%0d inflight", i), 32'(inflight),
          32'(tbl[i].inf));
      chk($sformatf("row%0d a_cnt", i), 32'(a_done_cnt), 32'(tbl[i].ac));
      chk($sformatf("row%0d b_cnt", i), 32'(b_done_cnt), 32'(tbl[i].bc));
      tick();
    end

    // reset while two products are in flight
    do_reset();
    b_valid = 1'b1;
    b_x = 16'd7;
    b_y = 16'd7;
    #1;
    chk("mid b_ready", 32'(b_ready), 1);
    tick();
    b_valid = 1'b0;
    a_valid = 1'b1;
    a_x = 16'd2;
    a_y = 16'd2;
    #1;
    chk("mid a_ready", 32'(a_ready), 1);
    tick();
    rst = 1'b1;
    b_valid = 1'b1;
    #1;
    chk("mid rst a_ready", 32'(a_ready), 0);
    chk("mid rst b_ready", 32'(b_ready), 0);
    tick();
    rst = 1'b0;
    idle_in();
    for (int c = 0; c < 8; c++) begin
      #1;
      chk($sformatf("mid c%0d a_p_valid", c), 32'(a_p_valid), 0);
      chk($sformatf("mid c%0d b_p_valid", c), 32'(b_p_valid), 0);
      tick();
    end
    chk("mid inflight", 32'(inflight), 0);
    chk("mid a_cnt", 32'(a_done_cnt), 0);
    chk("mid b_cnt", 32'(b_done_cnt), 0);
    a_valid = 1'b1;
    b_valid = 1'b1;
    #1;
    chk("mid tie a_ready", 32'(a_ready), 1);
    chk("mid tie b_ready", 32'(b_ready), 0);
    tick();

    // turn order with A streaming and going idle
    do_reset();
    for (int s = 0; s < 7; s++) begin
      a_valid = sa_av[s];
      b_valid = sa_bv[s];
      a_x = 16'(s + 1);
      b_x = 16'(s + 2);
      #1;
      chk($sformatf("stall s%0d a_ready", s), 32'(a_ready), 32'(sa_ar[s]));
      chk($sformatf("stall s%0d b_ready", s), 32'(b_ready), 32'(sa_br[s]));
      tick();
    end

    // counter wrap: 17 A deliveries
    do_reset();
    for (int i = 0; i < 17; i++) begin
      a_valid = 1'b1;
      a_x = 16'(i + 1);
      a_y = 16'd2;
      tick();
    end
    idle_in();
    for (int c = 0; c < 6; c++) tick();
    chk("wrap a_cnt16", 32'(a_done_cnt), 17);
    chk("wrap a_cnt4", 32'(w4_a_cnt), 1);
    chk("wrap a_p", a_p, 34);
    chk("wrap inflight", 32'(inflight), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
